// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler
// Arbitrates instruction fetches and load/store accesses onto one shared
// memory port. Only one access is in flight at a time. A data request beats
// a fetch request when both are seen in the same idle cycle.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   fetch_req, fetch_addr        instruction-fetch request
//   fetch_ack, fetch_data        one-cycle fetch completion, fetched word
//   should_read_mem/_write_mem   load/store strobes (both high = store)
//   data_addr, data_wdata        load/store address and store data
//   data_ack, data_rdata         one-cycle load/store completion, load word
//   stall                        holds the pipeline while a data access is open
//   mem_en, mem_we, mem_addr,
//   mem_wdata                    registered request to the shared memory
//   mem_rdata, mem_ready         memory response; completes when mem_ready=1
//   access_err                   with an ack: the access timed out
//
// Build option
//   MEM_ACCESS_TIMEOUT_EN  when defined, an access waiting TIMEOUT_CYCLES
//                          cycles without mem_ready is abandoned and acked
//                          with access_err=1 and zero read data. When not
//                          defined, accesses wait forever and access_err=0.
//
// state  | meaning
// IDLE   | no access open; arbitrating requests
// FETCH  | fetch request on the memory port, waiting for mem_ready
// DATA   | load/store request on the memory port, waiting for mem_ready
module mem_access_scheduler #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_data,
    input  logic        should_read_mem,
    input  logic        should_write_mem,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        access_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    logic [1:0] state;
    logic       data_req;
    logic       tmo;
    logic       done;

    assign data_req = should_read_mem | should_write_mem;
    assign stall    = data_req & ~data_ack;
    assign done     = (state != S_IDLE) && (mem_ready || tmo);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;
    logic             grant;

    assign grant      = (state == S_IDLE) && ((data_req && !data_ack) || fetch_req);
    // The wait that would bring the count to TIMEOUT_CYCLES ends the access;
    // mem_ready in that same cycle still takes priority.
    assign tmo        = (state != S_IDLE) && !mem_ready &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign access_err = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo;
            if (grant)
                tmo_cnt <= '0;
            else if (state != S_IDLE && !mem_ready)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo        = 1'b0;
    assign access_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            fetch_ack  <= 1'b0;
            data_ack   <= 1'b0;
            fetch_data <= 32'h0;
            data_rdata <= 32'h0;
        end else begin
            fetch_ack <= 1'b0;
            data_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Strobes seen during the data_ack cycle still belong to
                    // the instruction that just completed, so they are not
                    // granted a second time.
                    if (data_req && !data_ack) begin
                        state     <= S_DATA;
                        mem_en    <= 1'b1;
                        mem_we    <= should_write_mem;
                        mem_addr  <= data_addr;
                        mem_wdata <= should_write_mem ? data_wdata : 32'h0;
                    end else if (fetch_req) begin
                        state     <= S_FETCH;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= fetch_addr;
                        mem_wdata <= 32'h0;
                    end
                end
                S_FETCH: begin
                    if (done) begin
                        state      <= S_IDLE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        fetch_ack  <= 1'b1;
                        fetch_data <= mem_ready ? mem_rdata : 32'h0;
                    end
                end
                S_DATA: begin
                    if (done) begin
                        state    <= S_IDLE;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        data_ack <= 1'b1;
                        if (!mem_ready)
                            data_rdata <= 32'h0;
                        else if (!mem_we)
                            data_rdata <= mem_rdata;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_scheduler.sv
`timescale 1ns/1ps
module tb_mem_access_scheduler;

    localparam int TMO = 4;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int MAX_DLY = 3;
`else
    localparam int MAX_DLY = 6;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        should_read_mem = 1'b0;
    logic        should_write_mem = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        access_err;

    always #5 clk = ~clk;

    mem_access_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .access_err(access_err)
    );

    typedef struct packed { logic is_data; logic [31:0] data; logic err; } resp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

    resp_t exp_q[$];
    req_t  req_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] resp_mem  [logic [31:0]];
    logic [31:0] last_rdata = '0;
    int n_checks = 0;
    int n_fail = 0;
    int force_dly = -1;
    int en_cycles = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ack monitor / scoreboard
    always @(negedge clk) begin
        resp_t e;
        if (reset_n) begin
            if (mem_en) en_cycles++;
            chk1("stall", stall, (should_read_mem | should_write_mem) & ~data_ack);
            chk1("ack_overlap", fetch_ack & data_ack, 1'b0);
            if (fetch_ack || data_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: fetch_ack=%b data_ack=%b with nothing outstanding", fetch_ack, data_ack);
                end else begin
                    e = exp_q.pop_front();
                    chk1("ack_kind", data_ack, e.is_data);
                    if (e.is_data) chk32("data_rdata", data_rdata, e.data);
                    else           chk32("fetch_data", fetch_data, e.data);
                    chk1("access_err", access_err, e.err);
                end
            end else begin
                chk1("err_without_ack", access_err, 1'b0);
            end
        end
    end

    // Memory responder: checks the request it is handed and answers it
    bit   tracking = 0;
    bit   completing = 0;
    int   dly = 0;
    req_t cur;
    always @(posedge clk) begin
        req_t r;
        #1;
        if (!reset_n) begin
            tracking = 0; completing = 0; mem_ready = 1'b0;
        end else if (completing) begin
            if (cur.we) resp_mem[cur.addr] = cur.wdata;
            completing = 0; tracking = 0; mem_ready = 1'b0;
            chk1("mem_en_after_done", mem_en, 1'b0);
        end else if (mem_en) begin
            if (!tracking) begin
                tracking = 1;
                cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: addr %h", mem_addr);
                end else begin
                    r = req_q.pop_front();
                    chk1("mem_we", mem_we, r.we);
                    chk32("mem_addr", mem_addr, r.addr);
                    chk32("mem_wdata", mem_wdata, r.wdata);
                end
                dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, MAX_DLY));
            end else begin
                chk1("mem_we_hold", mem_we, cur.we);
                chk32("mem_addr_hold", mem_addr, cur.addr);
                chk32("mem_wdata_hold", mem_wdata, cur.wdata);
            end
            if (dly == 0) begin
                mem_ready = 1'b1; mem_rdata = resp_rd(cur.addr); completing = 1;
            end else begin
                dly--; mem_ready = 1'b0; mem_rdata = $urandom;
            end
        end else begin
            // mem_ready noise while nothing is open must be ignored
            tracking = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    task automatic do_reset();
        @(negedge clk); #2;
        reset_n = 1'b0;
        fetch_req = 1'b0; should_read_mem = 1'b0; should_write_mem = 1'b0;
        #1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_fetch_ack", fetch_ack, 1'b0);
        chk1("rst_data_ack", data_ack, 1'b0);
        chk1("rst_access_err", access_err, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_fetch_data", fetch_data, 32'h0);
        chk32("rst_data_rdata", data_rdata, 32'h0);
        exp_q.delete(); req_q.delete();
        last_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    // kind: 0 fetch, 1 read, 2 write, 3 read+write, 4 fetch+read, 5 fetch+write
    task automatic do_txn(input int kind, input logic [31:0] faddr, input logic [31:0] daddr,
                          input logic [31:0] wd, input bit drop_fetch);
        bit has_f, has_d, is_w, pend_f, pend_d;
        logic [31:0] v;
        int cycles;
        has_f = (kind == 0) || (kind >= 4);
        has_d = (kind != 0);
        is_w  = (kind == 2) || (kind == 3) || (kind == 5);
        @(negedge clk); #1;
        should_read_mem  = (kind == 1) || (kind == 3) || (kind == 4);
        should_write_mem = is_w;
        data_addr = daddr; data_wdata = wd;
        fetch_req = has_f; fetch_addr = faddr;
        if (has_d) begin
            req_q.push_back('{we: is_w, addr: daddr, wdata: is_w ? wd : 32'h0});
            if (is_w) begin
                model_mem[daddr] = wd;
                exp_q.push_back('{is_data: 1'b1, data: last_rdata, err: 1'b0});
            end else begin
                v = model_rd(daddr);
                last_rdata = v;
                exp_q.push_back('{is_data: 1'b1, data: v, err: 1'b0});
            end
        end
        if (has_f) begin
            req_q.push_back('{we: 1'b0, addr: faddr, wdata: 32'h0});
            exp_q.push_back('{is_data: 1'b0, data: model_rd(faddr), err: 1'b0});
        end
        pend_f = has_f; pend_d = has_d; cycles = 0;
        while ((pend_f || pend_d) && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (data_ack)  pend_d = 0;
            if (fetch_ack) pend_f = 0;
            #1;
            if (!pend_d) begin should_read_mem = 1'b0; should_write_mem = 1'b0; end
            if (!pend_f || drop_fetch) fetch_req = 1'b0;
        end
        if (pend_f || pend_d) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: kind %0d pending fetch=%0b data=%0b after %0d cycles", kind, pend_f, pend_d, cycles);
            do_reset();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int e0, acks, lat;

        do_reset();

        // Minimum latency fetch
        force_dly = 0;
        model_mem[32'h100] = 32'h13;
        resp_mem[32'h100]  = 32'h13;
        @(negedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h100;
        req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_q.push_back('{is_data: 1'b0, data: 32'h13, err: 1'b0});
        @(negedge clk);
        chk1("lat_mem_en_n1", mem_en, 1'b1);
        chk32("lat_mem_addr", mem_addr, 32'h100);
        chk1("lat_no_ack_n1", fetch_ack, 1'b0);
        #1 fetch_req = 1'b0;
        @(negedge clk);
        chk1("lat_fetch_ack_n2", fetch_ack, 1'b1);
        chk32("lat_fetch_data", fetch_data, 32'h13);
        chk1("lat_mem_en_n2", mem_en, 1'b0);

        // Data beats fetch in the same cycle
        force_dly = -1;
        do_txn(4, 32'h104, 32'h2000, 32'h0, 1'b0);

        // Store with delayed ready: request held for 4 cycles
        force_dly = 3;
        saved = data_rdata;
        e0 = en_cycles;
        do_txn(2, 32'h0, 32'h40, 32'hDEADBEEF, 1'b0);
        chk32("write_en_cycles", 32'(en_cycles - e0), 32'd4);
        chk32("write_keeps_rdata", data_rdata, saved);

        // Randomised traffic
        force_dly = -1;
        for (int i = 0; i < 150; i++) begin
            int k;
            k = int'($urandom_range(0, 5));
            do_txn(k, 32'h1000 + ($urandom_range(0, 15) << 2),
                   32'h1000 + ($urandom_range(0, 15) << 2), $urandom,
                   (k == 0) && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during an open fetch aborts it without an ack
        force_dly = 20;
        @(negedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h200;
        req_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
        exp_q.push_back('{is_data: 1'b0, data: model_rd(32'h200), err: 1'b0});
        repeat (3) @(negedge clk);
        chk1("abort_mem_en_open", mem_en, 1'b1);
        do_reset();
        force_dly = -1;
        do_txn(0, 32'h204, 32'h0, 32'h0, 1'b0);

        // Memory that never answers
        force_dly = 100000;
        @(negedge clk); #1;
        should_read_mem = 1'b1; data_addr = 32'h80;
        req_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
`ifdef MEM_ACCESS_TIMEOUT_EN
        exp_q.push_back('{is_data: 1'b1, data: 32'h0, err: 1'b1});
        last_rdata = '0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (data_ack) break;
        end
        chk32("timeout_latency", 32'(lat), 32'd5);
        #1 should_read_mem = 1'b0;
        force_dly = -1;
        do_txn(1, 32'h0, 32'h84, 32'h0, 1'b0);
`else
        exp_q.push_back('{is_data: 1'b1, data: model_rd(32'h80), err: 1'b0});
        acks = 0;
        repeat (300) begin
            @(negedge clk);
            if (data_ack || fetch_ack) acks++;
        end
        chk32("no_ack_300", 32'(acks), 32'd0);
        chk1("mem_en_held_300", mem_en, 1'b1);
        chk1("stall_held_300", stall, 1'b1);
        do_reset();
        force_dly = -1;
        do_txn(1, 32'h0, 32'h84, 32'h0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expected: %0d acks never seen", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_scheduler.md
MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles an access waits for mem_ready (Configuration REQ-024 only).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 fetch_req  input  1  instruction-fetch request; fetch_addr  input  32  fetch word address.
REQ-005 fetch_ack  output  1  one-cycle fetch completion pulse; fetch_data  output  32  fetched word, valid with fetch_ack.
REQ-006 should_read_mem, should_write_mem  input  1 each  decoded load/store strobes of the executing instruction.
REQ-007 data_addr  input  32  load/store address (ALU result); data_wdata  input  32  store data (reg or xmm per mem_write_src, muxed upstream).
REQ-008 data_ack  output  1  one-cycle load/store completion pulse; data_rdata  output  32  load result, valid with data_ack.
REQ-009 stall  output  1  freezes PC and pipeline while a data access is outstanding.
REQ-010 mem_en, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each  shared memory port request.
REQ-011 mem_rdata  input  32; mem_ready  input  1  memory completes current request when high.
REQ-012 access_err  output  1  high with fetch_ack/data_ack when access timed out.

Function
REQ-013 FSM states IDLE, FETCH, DATA; exactly one memory access in flight at any time.
REQ-014 IDLE: data request (should_read_mem|should_write_mem) wins over fetch_req; selected requester's state entered next edge; no request stays IDLE.
REQ-015 Both should_read_mem and should_write_mem high: treated as write; read ignored.
REQ-016 mem_en, mem_we, mem_addr, mem_wdata registered at grant edge, held constant until mem_ready sampled high; mem_we=0 in FETCH; mem_wdata=0 on reads.
REQ-017 mem_ready sampled high in FETCH/DATA: next edge deasserts mem_en/mem_we, pulses matching ack one cycle, registers mem_rdata into fetch_data/data_rdata (data_rdata unchanged on writes), returns to IDLE.
REQ-018 Minimum latency: request sampled cycle N, mem_en high N+1, ack high N+2 if mem_ready high in N+1; max throughput one access per 2 cycles.
REQ-019 stall = (should_read_mem|should_write_mem) & ~data_ack, combinational; low in cycle data_ack pulses.
REQ-020 Requester deasserting mid-access: access completes, ack still pulses; mem_ready in IDLE ignored.
REQ-021 fetch_data/data_rdata hold last value between acks.

Reset
REQ-022 reset_n low: immediately IDLE; mem_en, mem_we, fetch_ack, data_ack, access_err 0; mem_addr, mem_wdata, fetch_data, data_rdata 32'h0; timeout counter 0.
REQ-023 Reset mid-access aborts it with no ack; first request after reset_n rises is granted per REQ-014.

Configuration
REQ-024 MEM_ACCESS_TIMEOUT_EN defined: 8-bit+ counter clears on grant, increments each FETCH/DATA cycle without mem_ready; reaching TIMEOUT_CYCLES drops mem_en, pulses ack with access_err=1 and rdata 32'h0, returns IDLE; mem_ready in same cycle wins (normal completion).
REQ-025 MEM_ACCESS_TIMEOUT_EN undefined: no counter, access waits indefinitely, access_err tied 0.

Verification
REQ-026 Reset, fetch_req=1 addr 0x100, mem_ready=1 always, mem_rdata 0x00000013 -> mem_en at N+1, fetch_ack and fetch_data=0x13 at N+2.
REQ-027 fetch_req and should_read_mem same cycle, data_addr 0x2000 -> DATA first (mem_addr 0x2000), data_ack, then FETCH; stall low only at data_ack.
REQ-028 should_write_mem, addr 0x40, wdata 0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we/addr/wdata stable 4 cycles, data_ack once, data_rdata unchanged.
REQ-029 reset_n low during FETCH wait -> outputs zero immediately, no fetch_ack; next request served normally.
REQ-030 MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready=0 -> after 4 wait cycles data_ack=1, access_err=1, data_rdata 0; without macro -> mem_en held, no ack after 300 cycles.
